fifo_operand_reader: RTL and testbench
======================================

Name: fifo_operand_reader

Overview:
- Read-side controller for the team's synchronous FIFO, which has a registered read path: `data_o` is valid one cycle after a granted `rd_en` and holds its value otherwise.
- Pops two consecutive words (operand A, then operand B) and presents them as one pair to the GCD core through a valid/ready handshake.
- Also counts delivered pairs.
- Sits between the operand FIFO and the GCD datapath.

Parameters:
- DATA_WIDTH, 4, width of one FIFO word / one operand.
- CNT_WIDTH, 8, width of the delivered-pair counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- fifo_empty_i  input  1  FIFO empty flag (write pointer equals read pointer).
- fifo_data_i  input  DATA_WIDTH  FIFO registered read data.
- fifo_rd_en_o  output  1  pop request to the FIFO.
- op_a_o  output  DATA_WIDTH  operand A of the current pair.
- op_b_o  output  DATA_WIDTH  operand B of the current pair.
- op_valid_o  output  1  pair valid.
- op_ready_i  input  1  GCD core accepts the pair.
- pair_cnt_o  output  CNT_WIDTH  number of pairs accepted since reset.
- busy_o  output  1  high in every state except POP_A.

Behaviour:
- Reset (asynchronous, `rst_i`=1):
  - state is POP_A.
  - `op_a_o`=0, `op_b_o`=0, `op_valid_o`=0, `pair_cnt_o`=0, `busy_o`=0.
  - `fifo_rd_en_o`=0 while reset is held.
- States: POP_A, CAP_A, POP_B, CAP_B, PRESENT.
- POP_A:
  - `fifo_rd_en_o` = !`fifo_empty_i` (combinational).
  - If not empty, go to CAP_A; otherwise stay.
- CAP_A:
  - `a_q` <= `fifo_data_i`; go to POP_B.
  - `fifo_rd_en_o`=0.
- POP_B:
  - `fifo_rd_en_o` = !`fifo_empty_i`.
  - If not empty, go to CAP_B; otherwise stay and keep `a_q`. There is no timeout.
- CAP_B:
  - `b_q` <= `fifo_data_i`; go to PRESENT.
- PRESENT:
  - `op_valid_o`=1; `op_a_o`/`op_b_o` are stable.
  - On `op_ready_i`=1: `pair_cnt_o` increments, then go to POP_A.
  - `fifo_rd_en_o`=0 in this state.
- Outputs: `op_a_o`/`op_b_o` are registered copies of `a_q`/`b_q`. They change only in CAP states and hold their last values after the handshake.
- Handshake:
  - `op_valid_o` is registered.
  - Once asserted, it stays high and the data does not change until `op_ready_i` is sampled high.
  - `op_ready_i` is ignored outside PRESENT.
- Latency: with at least 2 words already in the FIFO, `op_valid_o` rises 4 cycles after entering POP_A. Minimum pair period is 5 cycles with ready tied high.
- At most one pop per two cycles, so the FIFO sees no back-to-back reads.
- `pair_cnt_o` wraps modulo 2^CNT_WIDTH (255 -> 0 at default).
- `fifo_empty_i` is sampled only in the POP states. A concurrent FIFO write does not affect the current cycle's pop decision.
- Reset mid-pair:
  - Return to POP_A; the partial pair is discarded.
  - A word already popped is lost, by design; the bench must not expect its recovery.
- Illegal state encodings recover to POP_A.

Decomposition:
- Shared package `gcd_pkg`:
  - state enum `rd_state_e` (POP_A, CAP_A, POP_B, CAP_B, PRESENT).
  - DATA_WIDTH default constant, shared with the FIFO and GCD core.
  - typedef `operand_t` = logic [DATA_WIDTH-1:0].
- Single module; no sub-module needed. The pair counter stays inline.

Test Plan:
- Write 12, then 8, into an empty FIFO; hold ready=1 -> after 4 cycles `op_a_o`=12, `op_b_o`=8, `op_valid_o`=1 for exactly one cycle; `pair_cnt_o`=1.
- FIFO holds only 9 -> A captured as 9, FSM waits in POP_B with `fifo_rd_en_o`=0. Write 6 after 10 cycles -> pair (9,6) presented 2 cycles later.
- Pair (15,5) presented, ready held low for 7 cycles -> `op_valid_o` and the data are stable for all 7 cycles, no pops occur, and the count increments only on the ready cycle.
- Fill the FIFO with 8 words (1..8), ready=1 -> pairs (1,2),(3,4),(5,6),(7,8), each 5 cycles apart; `fifo_rd_en_o` is never high two cycles in a row; `pair_cnt_o`=4.
- Assert `rst_i` in CAP_B of pair (4,10) -> outputs return to 0 immediately (asynchronous), `pair_cnt_o`=0, state POP_A; the next two words form a fresh pair.
- Preload `pair_cnt_o`=255 via 255 pairs, then deliver one more -> `pair_cnt_o` wraps to 0.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD operand path: the FIFO, the operand reader
// and the GCD core all use the same word width and reader state encoding.
package gcd_pkg;

    // Default operand width, shared with the FIFO and the GCD core.
    localparam int DATA_WIDTH = 4;

    typedef logic [DATA_WIDTH-1:0] operand_t;

    // Read-side sequencing: pop A, capture A, pop B, capture B, present pair.
    typedef enum logic [2:0] {
        POP_A   = 3'd0,
        CAP_A   = 3'd1,
        POP_B   = 3'd2,
        CAP_B   = 3'd3,
        PRESENT = 3'd4
    } rd_state_e;

endpackage

// File: rtl/fifo_operand_reader.sv
// fifo_operand_reader
//   Pops two consecutive words from a FIFO with a registered read path
//   (data appears the cycle after a granted pop) and presents them as an
//   (A, B) operand pair to the GCD core over valid/ready. Counts accepted
//   pairs modulo 2^CNT_WIDTH.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   fifo_empty_i     FIFO empty flag
//   fifo_data_i      FIFO registered read data
//   fifo_rd_en_o     pop request (never asserted on consecutive cycles)
//   op_a_o, op_b_o   current operand pair (registered, stable while valid)
//   op_valid_o       pair valid (registered)
//   op_ready_i       GCD core accepts the pair
//   pair_cnt_o       number of accepted pairs since reset
//   busy_o           high whenever the reader is not idle in POP_A
module fifo_operand_reader #(
    parameter int DATA_WIDTH = gcd_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_rd_en_o,
    output logic [DATA_WIDTH-1:0] op_a_o,
    output logic [DATA_WIDTH-1:0] op_b_o,
    output logic                  op_valid_o,
    input  logic                  op_ready_i,
    output logic [CNT_WIDTH-1:0]  pair_cnt_o,
    output logic                  busy_o
);
    import gcd_pkg::*;

    rd_state_e             state, state_next;
    logic [DATA_WIDTH-1:0] a_q;
    logic                  rd_en;
    logic                  valid_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= POP_A;
            a_q        <= '0;
            op_a_o     <= '0;
            op_b_o     <= '0;
            op_valid_o <= 1'b0;
            pair_cnt_o <= '0;
        end else begin
            state      <= state_next;
            op_valid_o <= valid_next;
            if (state == CAP_A)
                a_q <= fifo_data_i;
            // Both operands update together so the pair seen at the
            // outputs is always coherent; B comes straight off the FIFO.
            if (state == CAP_B) begin
                op_a_o <= a_q;
                op_b_o <= fifo_data_i;
            end
            if (state == PRESENT && op_ready_i)
                pair_cnt_o <= pair_cnt_o + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        valid_next = 1'b0;
        case (state)
            POP_A: begin
                rd_en = !fifo_empty_i;
                if (!fifo_empty_i)
                    state_next = CAP_A;
            end
            CAP_A: state_next = POP_B;
            POP_B: begin
                rd_en = !fifo_empty_i;
                if (!fifo_empty_i)
                    state_next = CAP_B;
            end
            CAP_B: begin
                state_next = PRESENT;
                valid_next = 1'b1;
            end
            PRESENT: begin
                valid_next = !op_ready_i;
                if (op_ready_i)
                    state_next = POP_A;
            end
            default: state_next = POP_A;
        endcase
    end

    // The reset state is POP_A, which would otherwise pop a non-empty FIFO
    // while reset is still held.
    assign fifo_rd_en_o = rd_en && !rst_i;
    assign busy_o       = (state != POP_A);

endmodule

// File: tb/tb_fifo_operand_reader.sv
module tb_fifo_operand_reader;
    localparam int DW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          rd_en;
    logic [DW-1:0] op_a, op_b;
    logic          op_valid;
    logic          ready = 1'b0;
    logic [CW-1:0] pair_cnt;
    logic          busy;

    always #5 clk = ~clk;

    fifo_operand_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst), .fifo_empty_i(fifo_empty),
        .fifo_data_i(fifo_data), .fifo_rd_en_o(rd_en), .op_a_o(op_a),
        .op_b_o(op_b), .op_valid_o(op_valid), .op_ready_i(ready),
        .pair_cnt_o(pair_cnt), .busy_o(busy)
    );

    // Behavioural FIFO: ring of words, write side driven by stimulus,
    // registered read side (data valid the cycle after a granted pop).
    logic [DW-1:0] mem [0:1023];
    int wr_cnt = 0;
    int rd_cnt = 0;
    assign fifo_empty = (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        if (rd_en && (wr_cnt != rd_cnt)) begin
            fifo_data <= mem[rd_cnt % 1024];
            rd_cnt    <= rd_cnt + 1;
        end
    end

    int nvec_s = 0, nerr_s = 0, nvec_c = 0, nerr_c = 0;

    task automatic chk_s(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec_s = nvec_s + 1;
        if (act !== exp) begin
            nerr_s = nerr_s + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_c(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec_c = nvec_c + 1;
        if (act !== exp) begin
            nerr_c = nerr_c + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: the words of the write stream, taken two at a time in
    // pop order, form the pairs; a reset discards a half-taken pair. The count
    // is the number of valid&&ready handshakes, modulo 2^CW.
    logic [2*DW-1:0] expq [$];
    logic [DW-1:0]   pend_a = '0;
    int              pend_n = 0;
    logic [CW-1:0]   model_cnt = '0;
    int              accepted = 0;
    int              cyc = 0, last_b_cyc = 0, idle_run = 0;
    logic            prev_valid = 1'b0, prev_ready = 1'b0, prev_rd = 1'b0;
    logic [DW-1:0]   prev_a = '0, prev_b = '0;
    logic [2*DW-1:0] ep;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            model_cnt = '0; pend_n = 0; expq.delete(); accepted = 0;
            prev_valid = 1'b0; prev_ready = 1'b0; prev_rd = 1'b0; idle_run = 0;
        end else begin
            chk_c("pair_cnt", pair_cnt, model_cnt);
            if (rd_en) begin
                chk_c("pop_when_empty", fifo_empty, 0);
                chk_c("pop_back_to_back", prev_rd, 0);
                chk_c("pop_while_valid", op_valid, 0);
                if (pend_n == 0) begin
                    pend_a = mem[rd_cnt % 1024];
                    pend_n = 1;
                end else begin
                    expq.push_back({pend_a, mem[rd_cnt % 1024]});
                    pend_n = 0;
                    last_b_cyc = cyc;
                end
            end
            if (prev_valid && !prev_ready) begin
                chk_c("valid_held", op_valid, 1);
                chk_c("a_held", op_a, prev_a);
                chk_c("b_held", op_b, prev_b);
            end else if (prev_valid) begin
                chk_c("valid_drop_after_accept", op_valid, 0);
                chk_c("busy_after_accept", busy, 0);
            end else if (op_valid) begin
                chk_c("pair_expected", (expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    ep = expq.pop_front();
                    chk_c("op_a", op_a, ep[2*DW-1:DW]);
                    chk_c("op_b", op_b, ep[DW-1:0]);
                    chk_c("latency_after_b_pop", cyc - last_b_cyc, 2);
                end
            end
            if (op_valid) chk_c("busy_while_valid", busy, 1);
            if (!fifo_empty && !op_valid && !rd_en) idle_run = idle_run + 1;
            else idle_run = 0;
            chk_c("stall_run_short", (idle_run < 2), 1);
            if (op_valid && ready) begin
                model_cnt = model_cnt + 1'b1;
                accepted  = accepted + 1;
            end
            prev_valid = op_valid; prev_ready = ready; prev_rd = rd_en;
            prev_a = op_a; prev_b = op_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wr_cnt % 1024] = w;
        wr_cnt = wr_cnt + 1;
    endtask

    initial begin
        int budget;
        rst = 1'b1;
        ready = 1'b0;
        tick(); tick();
        chk_s("rst_op_a", op_a, 0);
        chk_s("rst_op_b", op_b, 0);
        chk_s("rst_valid", op_valid, 0);
        chk_s("rst_cnt", pair_cnt, 0);
        chk_s("rst_busy", busy, 0);
        chk_s("rst_rd_en", rd_en, 0);
        rst = 1'b0;
        tick();

        // (12, 8), ready high: valid 4 cycles after the first pop, one cycle.
        ready = 1'b1;
        push(4'd12); push(4'd8);
        tick(); tick(); tick();
        chk_s("t1_valid_early", op_valid, 0);
        tick();
        chk_s("t1_valid", op_valid, 1);
        chk_s("t1_a", op_a, 12);
        chk_s("t1_b", op_b, 8);
        tick();
        chk_s("t1_valid_drop", op_valid, 0);
        chk_s("t1_cnt", pair_cnt, 1);

        // Only 9 available: wait in POP_B without popping, then 6 arrives.
        tick(); tick();
        push(4'd9);
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            chk_s("t2_wait_no_pop", rd_en, 0);
            chk_s("t2_wait_busy", busy, 1);
            tick();
        end
        push(4'd6);
        tick(); tick();
        chk_s("t2_valid", op_valid, 1);
        chk_s("t2_a", op_a, 9);
        chk_s("t2_b", op_b, 6);
        tick();
        chk_s("t2_cnt", pair_cnt, 2);

        // (15, 5) with ready low for 7 cycles.
        ready = 1'b0;
        tick(); tick();
        push(4'd15); push(4'd5);
        tick(); tick(); tick(); tick();
        for (int i = 0; i < 7; i++) begin
            chk_s("t3_valid_stable", op_valid, 1);
            chk_s("t3_a_stable", op_a, 15);
            chk_s("t3_b_stable", op_b, 5);
            chk_s("t3_no_pop", rd_en, 0);
            chk_s("t3_cnt_hold", pair_cnt, 2);
            tick();
        end
        ready = 1'b1;
        tick();
        chk_s("t3_cnt", pair_cnt, 3);
        chk_s("t3_valid_drop", op_valid, 0);

        // Eight words back to back: four pairs, five cycles apart.
        tick(); tick();
        for (int i = 1; i <= 8; i++) push(4'(i));
        tick(); tick(); tick(); tick();
        for (int p = 0; p < 4; p++) begin
            chk_s("t4_valid", op_valid, 1);
            chk_s("t4_a", op_a, 2*p + 1);
            chk_s("t4_b", op_b, 2*p + 2);
            if (p < 3) repeat (5) tick();
        end
        tick();
        chk_s("t4_cnt", pair_cnt, 7);

        // Reset in CAP_B of (4, 10); 7 stays in the FIFO and pairs with 3.
        tick(); tick();
        push(4'd4); push(4'd10); push(4'd7);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk_s("t5_rst_a", op_a, 0);
        chk_s("t5_rst_b", op_b, 0);
        chk_s("t5_rst_valid", op_valid, 0);
        chk_s("t5_rst_cnt", pair_cnt, 0);
        chk_s("t5_rst_busy", busy, 0);
        chk_s("t5_rst_no_pop", rd_en, 0);
        tick();
        chk_s("t5_rst_held_no_pop", rd_en, 0);
        rst = 1'b0;
        push(4'd3);
        tick(); tick(); tick(); tick();
        chk_s("t5_valid", op_valid, 1);
        chk_s("t5_a", op_a, 7);
        chk_s("t5_b", op_b, 3);
        tick();
        chk_s("t5_cnt", pair_cnt, 1);

        // Random traffic, random backpressure, occasional reset.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0 && (wr_cnt - rd_cnt) < 12)
                push(4'($urandom));
            ready = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        ready = 1'b1;
        repeat (40) tick();

        // Counter wrap: 255 pairs, then one more.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        budget = 0;
        while (accepted < 255 && budget < 3000) begin
            if ((wr_cnt - rd_cnt) < 4) push(4'($urandom));
            tick();
            budget++;
        end
        chk_s("wrap_reach_255_in_time", (accepted >= 255), 1);
        chk_s("wrap_cnt_255", pair_cnt, 255);
        budget = 0;
        while (accepted < 256 && budget < 100) begin
            if ((wr_cnt - rd_cnt) < 4) push(4'($urandom));
            tick();
            budget++;
        end
        chk_s("wrap_reach_256_in_time", (accepted >= 256), 1);
        chk_s("wrap_cnt_0", pair_cnt, 0);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec_s + nvec_c, nerr_s + nerr_c);
        $finish;
    end

endmodule
